fighter_anim_sequencer: RTL and testbench

//  Per-fighter animation scheduler driving the sprite renderer's character_state,

---
 rtl/fighter_anim_sequencer.sv | 134 +++++++++++++
 tb/tb_fighter_anim_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fighter_anim_sequencer.sv
// Per-fighter animation scheduler: arbitrates attack/hit requests, holds frames
// for HOLD_TICKS animation ticks and sequences attack -> cooldown -> idle.
module fighter_anim_sequencer #(
    parameter int PUNCH_FRAMES   = 3,
    parameter int SP_FRAMES      = 3,
    parameter int HIT_FRAMES     = 3,
    parameter int HOLD_TICKS     = 1,
    parameter int COOLDOWN_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       req_punch,
    input  logic       req_special,
    input  logic       req_hit,
    input  logic       move_fwd,
    input  logic       move_back,
    output logic [2:0] character_state,
    output logic [1:0] move_state,
    output logic [1:0] frame_idx,
    output logic       busy,
    output logic       anim_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_PUNCH, S_SPECIAL, S_HIT, S_COOLDOWN
    } state_t;

    localparam logic [1:0] PUNCH_LAST = 2'(PUNCH_FRAMES - 1);
    localparam logic [1:0] SP_LAST    = 2'(SP_FRAMES - 1);
    localparam logic [1:0] HIT_LAST   = 2'(HIT_FRAMES - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_TICKS - 1);
    localparam logic [3:0] CD_LAST    = 4'(COOLDOWN_TICKS - 1);

    state_t     state, state_nx;
    logic [3:0] hold_cnt, hold_nx;
    logic [3:0] cd_cnt, cd_nx;
    logic [1:0] frame_nx, last_frame;
    logic [2:0] cs_nx;
    logic [1:0] ms_nx;
    logic       done_nx;

    assign last_frame = (state == S_PUNCH)   ? PUNCH_LAST :
                        (state == S_SPECIAL) ? SP_LAST    : HIT_LAST;

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        cd_nx    = cd_cnt;
        frame_nx = frame_idx;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                hold_nx  = '0;
                cd_nx    = '0;
                frame_nx = '0;
                if (req_hit)          state_nx = S_HIT;
                else if (req_special) state_nx = S_SPECIAL;
                else if (req_punch)   state_nx = S_PUNCH;
            end
            S_PUNCH, S_SPECIAL, S_HIT: begin
                if (frame_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nx = '0;
                        if (frame_idx == last_frame) begin
                            done_nx  = 1'b1;
                            frame_nx = '0;
                            cd_nx    = '0;
                            state_nx = (state == S_HIT || COOLDOWN_TICKS == 0) ? S_IDLE : S_COOLDOWN;
                        end else begin
                            frame_nx = frame_idx + 2'd1;
                        end
                    end else begin
                        hold_nx = hold_cnt + 4'd1;
                    end
                end
                // A hit overrides any advance but anim_done above still stands
                if (req_hit) begin
                    state_nx = S_HIT;
                    frame_nx = '0;
                    hold_nx  = '0;
                end
            end
            S_COOLDOWN: begin
                if (frame_tick) begin
                    if (cd_cnt == CD_LAST) state_nx = S_IDLE;
                    else                   cd_nx    = cd_cnt + 4'd1;
                end
                if (req_hit) begin
                    state_nx = S_HIT;
                    frame_nx = '0;
                    hold_nx  = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        case (state_nx)
            S_PUNCH:   cs_nx = 3'b001;
            S_SPECIAL: cs_nx = 3'b010;
            S_HIT:     cs_nx = 3'b100;
            default:   cs_nx = 3'b000;
        endcase

        ms_nx = 2'b00;
        if (state_nx == S_IDLE) begin
            if (move_fwd && !move_back)      ms_nx = 2'b01;
            else if (move_back && !move_fwd) ms_nx = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            hold_cnt        <= '0;
            cd_cnt          <= '0;
            frame_idx       <= '0;
            character_state <= '0;
            move_state      <= '0;
            busy            <= 1'b0;
            anim_done       <= 1'b0;
        end else begin
            state           <= state_nx;
            hold_cnt        <= hold_nx;
            cd_cnt          <= cd_nx;
            frame_idx       <= frame_nx;
            character_state <= cs_nx;
            move_state      <= ms_nx;
            busy            <= (state_nx != S_IDLE);
            anim_done       <= done_nx;
        end
    end

endmodule

// File: tb/tb_fighter_anim_sequencer.sv
// Scoreboard bench: each row drives one cycle of inputs and queues the expected
// registered outputs {character_state, move_state, frame_idx, busy, anim_done}.
module tb_fighter_anim_sequencer;

    logic clk = 1'b0;
    logic reset, frame_tick, req_punch, req_special, req_hit, move_fwd, move_back;
    logic [2:0] cs1, cs2;
    logic [1:0] ms1, ms2, fi1, fi2;
    logic       busy1, busy2, done1, done2;

    int n_cmp  = 0;
    int n_fail = 0;

    // input row encoding {rst, tick, hit, special, punch, fwd, back}
    localparam logic [6:0] I_0 = 7'b0000000;
    localparam logic [6:0] I_R = 7'b1000000;
    localparam logic [6:0] I_T = 7'b0100000;
    localparam logic [6:0] I_H = 7'b0010000;
    localparam logic [6:0] I_S = 7'b0001000;
    localparam logic [6:0] I_P = 7'b0000100;
    localparam logic [6:0] I_F = 7'b0000010;
    localparam logic [6:0] I_B = 7'b0000001;

    typedef struct {
        logic [6:0] in;
        logic [8:0] exp;
    } row_t;

    row_t       stim_q[$];
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    fighter_anim_sequencer dut1 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .req_punch(req_punch), .req_special(req_special), .req_hit(req_hit),
        .move_fwd(move_fwd), .move_back(move_back),
        .character_state(cs1), .move_state(ms1), .frame_idx(fi1),
        .busy(busy1), .anim_done(done1)
    );

    fighter_anim_sequencer #(.HOLD_TICKS(3), .COOLDOWN_TICKS(0)) dut2 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .req_punch(req_punch), .req_special(req_special), .req_hit(req_hit),
        .move_fwd(move_fwd), .move_back(move_back),
        .character_state(cs2), .move_state(ms2), .frame_idx(fi2),
        .busy(busy2), .anim_done(done2)
    );

    function automatic logic [8:0] ev(input logic [2:0] cs, input logic [1:0] ms,
                                      input logic [1:0] fi, input logic b, input logic d);
        return {cs, ms, fi, b, d};
    endfunction

    task automatic add(input logic [6:0] in, input logic [8:0] exp);
        row_t r;
        r.in  = in;
        r.exp = exp;
        stim_q.push_back(r);
    endtask

    // Drive one row for a cycle and queue its expected post-edge outputs
    task automatic step(input row_t r);
        {reset, frame_tick, req_hit, req_special, req_punch, move_fwd, move_back} = r.in;
        exp_q.push_back(r.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [8:0] obs, e;
        row_t r;
        add(I_R,             ev(0, 0, 0, 0, 0));
        add(I_R | I_P | I_F, ev(0, 0, 0, 0, 0));
        add(I_0,             ev(0, 0, 0, 0, 0));
        add(I_P,             ev(3'b001, 0, 0, 1, 0));
        add(I_T,             ev(3'b001, 0, 1, 1, 0));
        add(I_R | I_F,       ev(0, 0, 0, 0, 0));
        add(I_0,             ev(0, 0, 0, 0, 0));
        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            step(r);
            obs = {cs1, ms1, fi1, busy1, done1};
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset row %0d: got %b want %b", n_cmp, obs, e);
            end
        end
    endtask

    task automatic test_punch;
        logic [8:0] obs, e;
        row_t r;
        add(I_R, ev(0, 0, 0, 0, 0));
        add(I_P, ev(3'b001, 0, 0, 1, 0));
        add(I_P, ev(3'b001, 0, 0, 1, 0));
        add(I_S, ev(3'b001, 0, 0, 1, 0));
        add(I_T, ev(3'b001, 0, 1, 1, 0));
        for (int i = 0; i < 3; i++) add(I_0, ev(3'b001, 0, 1, 1, 0));
        add(I_T, ev(3'b001, 0, 2, 1, 0));
        for (int i = 0; i < 3; i++) add(I_0, ev(3'b001, 0, 2, 1, 0));
        add(I_T, ev(0, 0, 0, 1, 1));
        add(I_P | I_F, ev(0, 0, 0, 1, 0));
        add(I_S,       ev(0, 0, 0, 1, 0));
        add(I_0,       ev(0, 0, 0, 1, 0));
        add(I_T,       ev(0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++) add(I_0, ev(0, 0, 0, 1, 0));
        add(I_T, ev(0, 0, 0, 0, 0));
        add(I_0, ev(0, 0, 0, 0, 0));
        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            step(r);
            obs = {cs1, ms1, fi1, busy1, done1};
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL punch row %0d: got %b want %b", n_cmp, obs, e);
            end
        end
    endtask

    task automatic test_hit_cases;
        logic [8:0] obs, e;
        row_t r;
        add(I_R, ev(0, 0, 0, 0, 0));
        // all three requests at once: hit wins
        add(I_P | I_S | I_H, ev(3'b100, 0, 0, 1, 0));
        add(I_T, ev(3'b100, 0, 1, 1, 0));
        add(I_T, ev(3'b100, 0, 2, 1, 0));
        add(I_T, ev(0, 0, 0, 0, 1));
        add(I_0, ev(0, 0, 0, 0, 0));
        // special beats punch; hit preempts on frame 2 without anim_done
        add(I_S | I_P, ev(3'b010, 0, 0, 1, 0));
        add(I_T, ev(3'b010, 0, 1, 1, 0));
        add(I_T, ev(3'b010, 0, 2, 1, 0));
        add(I_H, ev(3'b100, 0, 0, 1, 0));
        add(I_0, ev(3'b100, 0, 0, 1, 0));
        // restart inside HIT ignores a coincident tick
        add(I_T,       ev(3'b100, 0, 1, 1, 0));
        add(I_H | I_T, ev(3'b100, 0, 0, 1, 0));
        add(I_T,       ev(3'b100, 0, 1, 1, 0));
        add(I_T,       ev(3'b100, 0, 2, 1, 0));
        // hit at end of animation: restart and still pulse done
        add(I_T | I_H, ev(3'b100, 0, 0, 1, 1));
        add(I_P,       ev(3'b100, 0, 0, 1, 0));
        add(I_T,       ev(3'b100, 0, 1, 1, 0));
        add(I_T,       ev(3'b100, 0, 2, 1, 0));
        add(I_T,       ev(0, 0, 0, 0, 1));
        // hit accepted during cooldown
        add(I_P, ev(3'b001, 0, 0, 1, 0));
        add(I_T, ev(3'b001, 0, 1, 1, 0));
        add(I_T, ev(3'b001, 0, 2, 1, 0));
        add(I_T, ev(0, 0, 0, 1, 1));
        add(I_T, ev(0, 0, 0, 1, 0));
        add(I_H, ev(3'b100, 0, 0, 1, 0));
        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            step(r);
            obs = {cs1, ms1, fi1, busy1, done1};
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL hit row %0d: got %b want %b", n_cmp, obs, e);
            end
        end
    endtask

    task automatic test_hold_ticks;
        logic [8:0] obs, e;
        row_t r;
        add(I_R, ev(0, 0, 0, 0, 0));
        add(I_P | I_T, ev(3'b001, 0, 0, 1, 0));
        add(I_T, ev(3'b001, 0, 0, 1, 0));
        add(I_T, ev(3'b001, 0, 0, 1, 0));
        add(I_0, ev(3'b001, 0, 0, 1, 0));
        add(I_T, ev(3'b001, 0, 1, 1, 0));
        add(I_T, ev(3'b001, 0, 1, 1, 0));
        add(I_T, ev(3'b001, 0, 1, 1, 0));
        add(I_T, ev(3'b001, 0, 2, 1, 0));
        add(I_T, ev(3'b001, 0, 2, 1, 0));
        add(I_T, ev(3'b001, 0, 2, 1, 0));
        // zero cooldown: straight back to idle
        add(I_T, ev(0, 0, 0, 0, 1));
        add(I_0, ev(0, 0, 0, 0, 0));
        // hit restart clears a partial hold
        add(I_H, ev(3'b100, 0, 0, 1, 0));
        add(I_T, ev(3'b100, 0, 0, 1, 0));
        add(I_H, ev(3'b100, 0, 0, 1, 0));
        add(I_T, ev(3'b100, 0, 0, 1, 0));
        add(I_T, ev(3'b100, 0, 0, 1, 0));
        add(I_T, ev(3'b100, 0, 1, 1, 0));
        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            step(r);
            obs = {cs2, ms2, fi2, busy2, done2};
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL hold row %0d: got %b want %b", n_cmp, obs, e);
            end
        end
    endtask

    task automatic test_move;
        logic [8:0] obs, e;
        row_t r;
        add(I_R,       ev(0, 0, 0, 0, 0));
        add(I_F | I_B, ev(0, 2'b00, 0, 0, 0));
        add(I_F,       ev(0, 2'b01, 0, 0, 0));
        add(I_B,       ev(0, 2'b10, 0, 0, 0));
        add(I_0,       ev(0, 2'b00, 0, 0, 0));
        add(I_F,       ev(0, 2'b01, 0, 0, 0));
        add(I_F | I_P, ev(3'b001, 2'b00, 0, 1, 0));
        add(I_F,       ev(3'b001, 2'b00, 0, 1, 0));
        add(I_B | I_T, ev(3'b001, 2'b00, 1, 1, 0));
        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            step(r);
            obs = {cs1, ms1, fi1, busy1, done1};
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL move row %0d: got %b want %b", n_cmp, obs, e);
            end
        end
    endtask

    initial begin
        {reset, frame_tick, req_hit, req_special, req_punch, move_fwd, move_back} = I_R;
        #1;
        test_reset();
        test_punch();
        test_hit_cases();
        test_hold_ticks();
        test_move();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
